mux_select_bank: RTL and testbench

- Registered multi-width selector bank: one shared set of 32 N-bit data inputs and one 5-bit select.
- Produces three simultaneous selections:
  - a 2:1 pick, using s[0] over in0..in1
  - a 16:1 pick, using s[3:0] over in0..in15
  - a 32:1 pick, using the full s over in0..in31
- Used wherever a register-file-style read port or operand steering needs several select widths from the same source bus.
- All outputs are registered: one clock of latency.

---
 rtl/mux_select_bank.sv | 100 ++++++++++
 tb/tb_mux_select_bank.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mux_select_bank.sv
// Registered 2:1, 16:1 and 32:1 selections from one shared 32-entry input bus.
// Latency: one clk cycle from s/in* sampled at an ena edge to out2/out16/out32.
// Backpressure: none; ena=0 holds all three outputs, rst clears them and overrides ena.
module mux_select_bank #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [4:0]   s,
    input  logic [N-1:0] in0,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic [N-1:0] in3,
    input  logic [N-1:0] in4,
    input  logic [N-1:0] in5,
    input  logic [N-1:0] in6,
    input  logic [N-1:0] in7,
    input  logic [N-1:0] in8,
    input  logic [N-1:0] in9,
    input  logic [N-1:0] in10,
    input  logic [N-1:0] in11,
    input  logic [N-1:0] in12,
    input  logic [N-1:0] in13,
    input  logic [N-1:0] in14,
    input  logic [N-1:0] in15,
    input  logic [N-1:0] in16,
    input  logic [N-1:0] in17,
    input  logic [N-1:0] in18,
    input  logic [N-1:0] in19,
    input  logic [N-1:0] in20,
    input  logic [N-1:0] in21,
    input  logic [N-1:0] in22,
    input  logic [N-1:0] in23,
    input  logic [N-1:0] in24,
    input  logic [N-1:0] in25,
    input  logic [N-1:0] in26,
    input  logic [N-1:0] in27,
    input  logic [N-1:0] in28,
    input  logic [N-1:0] in29,
    input  logic [N-1:0] in30,
    input  logic [N-1:0] in31,
    output logic [N-1:0] out2,
    output logic [N-1:0] out16,
    output logic [N-1:0] out32
);

    // Gather the flat ports into an array so the tree can be built with loops.
    logic [N-1:0] din [32];

    assign din[0]  = in0;   assign din[1]  = in1;   assign din[2]  = in2;   assign din[3]  = in3;
    assign din[4]  = in4;   assign din[5]  = in5;   assign din[6]  = in6;   assign din[7]  = in7;
    assign din[8]  = in8;   assign din[9]  = in9;   assign din[10] = in10;  assign din[11] = in11;
    assign din[12] = in12;  assign din[13] = in13;  assign din[14] = in14;  assign din[15] = in15;
    assign din[16] = in16;  assign din[17] = in17;  assign din[18] = in18;  assign din[19] = in19;
    assign din[20] = in20;  assign din[21] = in21;  assign din[22] = in22;  assign din[23] = in23;
    assign din[24] = in24;  assign din[25] = in25;  assign din[26] = in26;  assign din[27] = in27;
    assign din[28] = in28;  assign din[29] = in29;  assign din[30] = in30;  assign din[31] = in31;

    // Binary tree of 2:1 stages, one select bit per level.
    // lvl1[k] picks from pair k with s[0]; lvl4[0] covers in0..in15, lvl4[1] covers in16..in31.
    logic [N-1:0] lvl1 [16];
    logic [N-1:0] lvl2 [8];
    logic [N-1:0] lvl3 [4];
    logic [N-1:0] lvl4 [2];
    logic [N-1:0] sel32;

    genvar k;
    generate
        for (k = 0; k < 16; k++) begin : g_lvl1
            assign lvl1[k] = s[0] ? din[2*k+1] : din[2*k];
        end
        for (k = 0; k < 8; k++) begin : g_lvl2
            assign lvl2[k] = s[1] ? lvl1[2*k+1] : lvl1[2*k];
        end
        for (k = 0; k < 4; k++) begin : g_lvl3
            assign lvl3[k] = s[2] ? lvl2[2*k+1] : lvl2[2*k];
        end
        for (k = 0; k < 2; k++) begin : g_lvl4
            assign lvl4[k] = s[3] ? lvl3[2*k+1] : lvl3[2*k];
        end
    endgenerate

    // Top bit chooses between the lower and upper 16:1 halves.
    assign sel32 = s[4] ? lvl4[1] : lvl4[0];

    // Output registers: reset wins, otherwise load on ena, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out2  <= '0;
            out16 <= '0;
            out32 <= '0;
        end else if (ena) begin
            out2  <= lvl1[0];
            out16 <= lvl4[0];
            out32 <= sel32;
        end
    end

endmodule

// File: tb/tb_mux_select_bank.sv
// Directed self-checking bench for mux_select_bank.
// Inputs are driven on the falling edge, outputs sampled on the falling edge after capture.
// Covers reset, full select sweep, latency, hold, reset priority and full-width data.
module tb_mux_select_bank;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [4:0]  s;
    logic [31:0] din [32];
    logic [31:0] out2;
    logic [31:0] out16;
    logic [31:0] out32;

    int n_checks;
    int n_fail;

    mux_select_bank #(.N(32)) dut (
        .clk(clk), .rst(rst), .ena(ena), .s(s),
        .in0(din[0]),   .in1(din[1]),   .in2(din[2]),   .in3(din[3]),
        .in4(din[4]),   .in5(din[5]),   .in6(din[6]),   .in7(din[7]),
        .in8(din[8]),   .in9(din[9]),   .in10(din[10]), .in11(din[11]),
        .in12(din[12]), .in13(din[13]), .in14(din[14]), .in15(din[15]),
        .in16(din[16]), .in17(din[17]), .in18(din[18]), .in19(din[19]),
        .in20(din[20]), .in21(din[21]), .in22(din[22]), .in23(din[23]),
        .in24(din[24]), .in25(din[25]), .in26(din[26]), .in27(din[27]),
        .in28(din[28]), .in29(din[29]), .in30(din[30]), .in31(din[31]),
        .out2(out2), .out16(out16), .out32(out32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e2, input logic [31:0] e16,
                             input logic [31:0] e32);
        check_val({tag, "_out2"},  out2,  e2);
        check_val({tag, "_out16"}, out16, e16);
        check_val({tag, "_out32"}, out32, e32);
    endtask

    // One rising edge, then return on the following falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] e2, e16, e32;
        n_checks = 0;
        n_fail   = 0;

        // Reset with all inputs nonzero and ena asserted.
        @(negedge clk);
        for (int i = 0; i < 32; i++) din[i] = 32'hC0DE_0000 | 32'(i + 1);
        rst = 1'b1;
        ena = 1'b1;
        s   = 5'd3;
        step();
        check_all("rst_cyc1", 32'd0, 32'd0, 32'd0);
        step();
        check_all("rst_cyc2", 32'd0, 32'd0, 32'd0);
        rst = 1'b0;
        ena = 1'b0;
        step();
        check_all("rst_release_hold", 32'd0, 32'd0, 32'd0);

        // Full sweep with in_i = (i+1)^2.
        for (int i = 0; i < 32; i++) din[i] = 32'((i + 1) * (i + 1));
        ena = 1'b1;
        for (int v = 0; v < 32; v++) begin
            s = 5'(v);
            step();
            e32 = 32'((v + 1) * (v + 1));
            e16 = 32'(((v % 16) + 1) * ((v % 16) + 1));
            e2  = (v % 2 == 1) ? 32'd4 : 32'd1;
            check_all($sformatf("sweep_s%0d", v), e2, e16, e32);
            if (v == 5)  check_all("spot_s5",  32'd4, 32'd36,  32'd36);
            if (v == 17) check_all("spot_s17", 32'd4, 32'd4,   32'd324);
            if (v == 31) check_all("spot_s31", 32'd4, 32'd256, 32'd1024);
        end

        // Latency: s 0 -> 31 on consecutive cycles.
        s = 5'd0;
        step();
        check_val("lat_s0_out32", out32, 32'd1);
        s = 5'd31;
        #1;
        check_val("lat_no_comb_path", out32, 32'd1);
        step();
        check_val("lat_s31_out32", out32, 32'd1024);

        // Hold: load s=9, then freeze while s and in9 move.
        s = 5'd9;
        step();
        check_all("hold_load", 32'd4, 32'd100, 32'd100);
        ena     = 1'b0;
        s       = 5'd20;
        din[9]  = 32'd7;
        step();
        check_all("hold_cyc1", 32'd4, 32'd100, 32'd100);
        step();
        check_all("hold_cyc2", 32'd4, 32'd100, 32'd100);
        ena = 1'b1;
        step();
        check_all("hold_resume", 32'd1, 32'd25, 32'd441);

        // Reset priority over ena.
        rst = 1'b1;
        s   = 5'd31;
        step();
        check_all("rst_priority", 32'd0, 32'd0, 32'd0);
        rst = 1'b0;

        // Full-width data pass-through.
        din[31] = 32'hFFFF_FFFF;
        din[15] = 32'hA5A5_A5A5;
        s       = 5'd31;
        step();
        check_all("width", 32'd4, 32'hA5A5_A5A5, 32'hFFFF_FFFF);

        // Mid-operation reset clears, and outputs stay 0 while ena is low.
        rst = 1'b1;
        ena = 1'b0;
        step();
        check_all("rst_mid", 32'd0, 32'd0, 32'd0);
        rst = 1'b0;
        step();
        check_all("rst_mid_after", 32'd0, 32'd0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
